// File: rtl/tx_pcs_pkg.sv
// Shared TX PCS definitions: sequencer state encoding,
// stage-enable bit positions and default AM geometry.
package tx_pcs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RUN       = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } tx_state_e;

   localparam int STG_VALID_GEN    = 0;
   localparam int STG_ENCODER      = 1;
   localparam int STG_SCRAMBLER    = 2;
   localparam int STG_LANE_DIST    = 3;
   localparam int STG_BIP_CALC     = 4;
   localparam int STG_AM_MAPPER    = 5;
   localparam int STG_AM_INSERTION = 6;

   localparam int DEF_N_STAGES        = STG_AM_INSERTION + 1;
   localparam int DEF_AM_BLOCK_PERIOD = 16383;
   localparam int DEF_N_LANES         = 20;

endpackage

// File: rtl/tx_am_window_counter.sv
// Alignment-marker period/window tracker: counts data blocks,
// then flags the following N_LANES valid blocks as AM slots.
module tx_am_window_counter
   import tx_pcs_pkg::*;
#(
   parameter int AM_BLOCK_PERIOD = DEF_AM_BLOCK_PERIOD,
   parameter int N_LANES         = DEF_N_LANES
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_run,
   input  logic i_valid,
   output logic o_win_open,
   output logic o_win_last,
   output logic o_slot
);

   localparam int BLK_W  = $clog2(AM_BLOCK_PERIOD + 1);
   localparam int LANE_W = $clog2(N_LANES + 1);

   logic [BLK_W-1:0]  r_blk;
   logic [LANE_W-1:0] r_lane;
   logic              r_win;
   logic              w_blk_end;
   logic              w_lane_end;

   assign w_blk_end  = (r_blk == BLK_W'(AM_BLOCK_PERIOD - 1));
   assign w_lane_end = (r_lane == LANE_W'(N_LANES - 1));

   assign o_win_open = r_win;
   assign o_slot     = i_run & i_valid & r_win;
   assign o_win_last = o_slot & w_lane_end;

   // Block counter clears as it reaches the period and opens a window;
   // counters hold on idle cycles and clear whenever not running.
   always_ff @(posedge i_clock) begin
      if (!i_reset || !i_run) begin
         r_blk  <= '0;
         r_lane <= '0;
         r_win  <= 1'b0;
      end else if (i_valid) begin
         if (r_win) begin
            if (w_lane_end) begin
               r_lane <= '0;
               r_win  <= 1'b0;
            end else begin
               r_lane <= r_lane + LANE_W'(1);
            end
         end else if (w_blk_end) begin
            r_blk <= '0;
            r_win <= 1'b1;
         end else begin
            r_blk <= r_blk + BLK_W'(1);
         end
      end
   end

endmodule

// File: rtl/tx_enable_sequencer.sv
// TX chain enable sequencer: staged ramp up/down plus AM slot marking.
// Optional AM window counter port enabled by TX_ENABLE_SEQUENCER_AM_CNT_EN.
module tx_enable_sequencer
   import tx_pcs_pkg::*;
#(
   parameter int N_STAGES        = DEF_N_STAGES,
   parameter int STAGE_GAP       = 4,
   parameter int AM_BLOCK_PERIOD = DEF_AM_BLOCK_PERIOD,
   parameter int N_LANES         = DEF_N_LANES
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_valid,
   output logic [N_STAGES-1:0] o_enb,
   output logic                o_am_slot,
   output logic                o_running,
`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
   output logic [15:0]         o_am_count,
`endif
   output logic                o_busy
);

   tx_state_e           r_state;
   tx_state_e           w_state_nxt;
   logic [N_STAGES-1:0] r_enb;
   logic [N_STAGES-1:0] w_enb_nxt;
   logic [7:0]          r_timer;
   logic [7:0]          w_timer_nxt;
   logic                r_stop_pend;
   logic                w_stop_pend_nxt;
   logic                w_run;
   logic                w_gap_done;
   logic                w_stop_req;
   logic                w_win_open;
   logic                w_win_last;

   assign w_run      = (r_state == ST_RUN);
   assign w_gap_done = (r_timer == 8'(STAGE_GAP - 1));
   assign w_stop_req = i_stop | r_stop_pend;

   assign o_enb     = r_enb;
   assign o_running = w_run;
   assign o_busy    = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);

   tx_am_window_counter #(
      .AM_BLOCK_PERIOD(AM_BLOCK_PERIOD),
      .N_LANES        (N_LANES)
   ) u_am_win (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_run     (w_run),
      .i_valid   (i_valid),
      .o_win_open(w_win_open),
      .o_win_last(w_win_last),
      .o_slot    (o_am_slot)
   );

   // State, enable pattern, gap timer and deferred-stop flag registers
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_enb       <= '0;
         r_timer     <= '0;
         r_stop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_enb       <= w_enb_nxt;
         r_timer     <= w_timer_nxt;
         r_stop_pend <= w_stop_pend_nxt;
      end
   end

   // Next-state logic; each ramp transition applies its first step at once
   always_comb begin
      w_state_nxt     = r_state;
      w_enb_nxt       = r_enb;
      w_timer_nxt     = r_timer;
      w_stop_pend_nxt = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               w_state_nxt = ST_RAMP_UP;
               w_enb_nxt   = N_STAGES'(1);
               w_timer_nxt = '0;
            end
         end
         ST_RAMP_UP: begin
            if (i_stop) begin
               w_state_nxt = ST_RAMP_DOWN;
               w_enb_nxt   = r_enb >> 1;
               w_timer_nxt = '0;
            end else if (r_enb[N_STAGES-1]) begin
               w_state_nxt = ST_RUN;
               w_timer_nxt = '0;
            end else if (w_gap_done) begin
               w_enb_nxt   = (r_enb << 1) | N_STAGES'(1);
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 8'd1;
            end
         end
         ST_RUN: begin
            if (w_stop_req && (!w_win_open || w_win_last)) begin
               w_state_nxt = ST_RAMP_DOWN;
               w_enb_nxt   = r_enb >> 1;
               w_timer_nxt = '0;
            end else begin
               w_stop_pend_nxt = w_stop_req;
            end
         end
         ST_RAMP_DOWN: begin
            if (r_enb == '0) begin
               w_state_nxt = ST_IDLE;
            end else if (w_gap_done) begin
               w_enb_nxt   = r_enb >> 1;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_enb_nxt   = '0;
            w_timer_nxt = '0;
         end
      endcase
   end

`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
   logic [15:0] r_am_count;

   assign o_am_count = r_am_count;

   // Completed AM windows, saturating; only reset clears it
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_am_count <= '0;
      end else if (w_win_last && (r_am_count != 16'hFFFF)) begin
         r_am_count <= r_am_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tx_enable_sequencer.sv
// Directed bench for tx_enable_sequencer: ramps, AM windows,
// deferred stop, conflicts and mid-window reset.
module tb_tx_enable_sequencer;

   localparam int NS  = 7;
   localparam int GAP = 4;
   localparam int PER = 100;
   localparam int NL  = 20;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_start = 1'b0;
   logic          i_stop  = 1'b0;
   logic          i_valid = 1'b0;
   logic [NS-1:0] o_enb;
   logic          o_am_slot;
   logic          o_running;
   logic          o_busy;
`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
   logic [15:0]   o_am_count;
`endif

   int total = 0;
   int bad   = 0;

   tx_enable_sequencer #(
      .N_STAGES       (NS),
      .STAGE_GAP      (GAP),
      .AM_BLOCK_PERIOD(PER),
      .N_LANES        (NL)
   ) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_stop    (i_stop),
      .i_valid   (i_valid),
      .o_enb     (o_enb),
      .o_am_slot (o_am_slot),
      .o_running (o_running),
`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
      .o_am_count(o_am_count),
`endif
      .o_busy    (o_busy)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clock);
      #1;
   endtask

   function automatic bit exp_slot(input int b);
      return ((b - 1) % (PER + NL)) >= PER;
   endfunction

   task automatic ramp_up();
      int k;
      i_start = 1'b1;
      cyc();
      for (int c = 0; c <= 25; c++) begin
         k = (c / GAP > 6) ? 6 : c / GAP;
         check("up_enb", 32'(o_enb), (32'd1 << (k + 1)) - 32'd1);
         check("up_run", 32'(o_running), 32'(c == 25));
         check("up_busy", 32'(o_busy), 32'(c < 25));
         if (c < 25) cyc();
      end
      i_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cyc();
      cyc();
      check("rst_enb", 32'(o_enb), 32'h0);
      check("rst_run", 32'(o_running), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_slot", 32'(o_am_slot), 32'h0);
      i_reset = 1'b1;

      ramp_up();

      for (int b = 1; b <= 360; b++) begin
         i_valid = 1'b1;
         i_stop  = (b == 345);
         #1;
         check("am_slot", 32'(o_am_slot), 32'(exp_slot(b)));
         if (b > 345) check("defer_run", 32'(o_running), 32'h1);
         cyc();
         i_valid = 1'b0;
         i_stop  = 1'b0;
         if (b < 360) begin
            #1;
            check("gap_slot", 32'(o_am_slot), 32'h0);
            cyc();
         end
      end

      for (int c = 0; c <= 25; c++) begin
         check("dn_enb", 32'(o_enb), 32'h7F >> (1 + c / GAP));
         check("dn_busy", 32'(o_busy), 32'(c < 25));
         check("dn_run", 32'(o_running), 32'h0);
         i_start = (c >= 8 && c < 16);
         if (c < 25) cyc();
      end
      i_start = 1'b0;
`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
      check("am_count3", 32'(o_am_count), 32'd3);
`endif

      i_start = 1'b1;
      i_stop  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         check("conf_enb", 32'(o_enb), 32'h0);
         check("conf_busy", 32'(o_busy), 32'h0);
      end
      i_stop = 1'b0;

      cyc();
      for (int c = 0; c <= 9; c++) begin
         check("sr_up_enb", 32'(o_enb), (32'd1 << (c / GAP + 1)) - 32'd1);
         if (c == 9) begin
            i_stop  = 1'b1;
            i_start = 1'b0;
         end
         cyc();
      end
      i_stop = 1'b0;
      for (int e = 0; e <= 9; e++) begin
         check("sr_dn_enb", 32'(o_enb), e < 4 ? 32'h3 : (e < 8 ? 32'h1 : 32'h0));
         check("sr_dn_busy", 32'(o_busy), 32'(e < 9));
         if (e < 9) cyc();
      end

      ramp_up();
      for (int b = 1; b <= 103; b++) begin
         i_valid = 1'b1;
         i_stop  = (b == 101);
         i_reset = (b != 103);
         #1;
         check("rw_slot", 32'(o_am_slot), 32'(exp_slot(b)));
         cyc();
      end
      check("rw_enb", 32'(o_enb), 32'h0);
      check("rw_run", 32'(o_running), 32'h0);
      check("rw_busy", 32'(o_busy), 32'h0);
      check("rw_slot0", 32'(o_am_slot), 32'h0);
`ifdef TX_ENABLE_SEQUENCER_AM_CNT_EN
      check("rw_count", 32'(o_am_count), 32'h0);
`endif
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_stop  = 1'b0;
      cyc();
      cyc();
      check("post_busy", 32'(o_busy), 32'h0);
      check("post_run", 32'(o_running), 32'h0);

      ramp_up();
      cyc();
      check("no_pend_run", 32'(o_running), 32'h1);
      check("no_pend_enb", 32'(o_enb), 32'h7F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
